// File: rtl/uart_echo_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_if
//  Purpose  : Serial line pair of the UART echo block. The master side drives
//             the receive line and observes the transmit line. The slave side
//             is the echo core.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_echo_if;
  logic uart_rx_i;  // serial input to the echo core, idle high
  logic uart_tx_o;  // serial output from the echo core, idle high

  modport master (output uart_rx_i, input uart_tx_o);
  modport slave  (input uart_rx_i, output uart_tx_o);
endinterface
`default_nettype wire

// File: rtl/uart_echo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo
//  Purpose  : UART loopback for 8N1 frames. The design has an RX deserializer,
//             a small byte FIFO and a TX serializer. Each correctly framed byte
//             is retransmitted unchanged.
//  Revision : 1.0  initial release
// ============================================================================
module uart_echo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  wire        clk,
  input  wire        rst,
  uart_echo_if.slave uart
);

  localparam int c_CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
  localparam int c_CNT_W        = (c_CLKS_PER_BIT > 2) ? $clog2(c_CLKS_PER_BIT) : 1;
  localparam int c_PTR_W        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF   = c_CNT_W'(c_HALF_BIT - 1);
  // The synchronizer delays the line by about two clocks. The end-of-stop
  // wait is shortened by one clock so the echo starts promptly. It still
  // never starts before the real stop bit has ended.
  localparam logic [c_CNT_W-1:0] c_CNT_FINISH = c_CNT_W'(c_HALF_BIT - 2);
  localparam logic [c_PTR_W:0]   c_FIFO_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] c_RX_IDLE   = 3'd0;
  localparam logic [2:0] c_RX_START  = 3'd1;
  localparam logic [2:0] c_RX_DATA   = 3'd2;
  localparam logic [2:0] c_RX_STOP   = 3'd3;
  localparam logic [2:0] c_RX_FINISH = 3'd4;
  localparam logic [2:0] c_RX_BREAK  = 3'd5;

  localparam logic [1:0] c_TX_IDLE  = 2'd0;
  localparam logic [1:0] c_TX_START = 2'd1;
  localparam logic [1:0] c_TX_DATA  = 2'd2;
  localparam logic [1:0] c_TX_STOP  = 2'd3;

  // ---------------------------------------------------------------- RX ----
  logic               r_rx_meta;
  logic               r_rx_sync;
  logic [2:0]         r_rx_state;
  logic [c_CNT_W-1:0] r_rx_cnt;
  logic [2:0]         r_rx_idx;
  logic [7:0]         r_rx_data;
  logic               w_push;

  // Two-flop synchronizer on the asynchronous serial input, idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart.uart_rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  // RX frame FSM. Data bits are shifted in LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= c_RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_data  <= '0;
    end else begin
      case (r_rx_state)
        c_RX_IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rx_sync) r_rx_state <= c_RX_START;
        end
        c_RX_START: begin
          if (r_rx_cnt == c_CNT_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_sync ? c_RX_IDLE : c_RX_DATA;  // glitch reject
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        c_RX_DATA: begin
          if (r_rx_cnt == c_CNT_LAST) begin
            r_rx_cnt  <= '0;
            r_rx_data <= {r_rx_sync, r_rx_data[7:1]};
            r_rx_idx  <= r_rx_idx + 1'b1;
            if (r_rx_idx == 3'd7) r_rx_state <= c_RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        c_RX_STOP: begin
          if (r_rx_cnt == c_CNT_LAST) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_sync ? c_RX_FINISH : c_RX_BREAK;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        c_RX_FINISH: begin
          if (r_rx_cnt == c_CNT_FINISH) begin
            r_rx_cnt   <= '0;
            r_rx_state <= c_RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        c_RX_BREAK: begin
          // Framing error: drop the byte and wait for the line to go idle.
          r_rx_cnt <= '0;
          if (r_rx_sync) r_rx_state <= c_RX_IDLE;
        end
        default: r_rx_state <= c_RX_IDLE;
      endcase
    end
  end

  assign w_push = (r_rx_state == c_RX_FINISH) && (r_rx_cnt == c_CNT_FINISH);

  // -------------------------------------------------------------- FIFO ----
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_do_pop;
  logic               w_do_push;
  logic [7:0]         w_rdata;

  assign w_full    = (r_count == c_FIFO_FULL);
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = w_pop && !w_empty;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign w_do_push = w_push && (!w_full || w_do_pop);
  assign w_rdata   = r_mem[r_rd_ptr];

  // FIFO storage. An overflowing push leaves the stored data unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= r_rx_data;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX ----
  logic [1:0]         r_tx_state;
  logic [c_CNT_W-1:0] r_tx_cnt;
  logic [2:0]         r_tx_idx;
  logic [7:0]         r_tx_shift;
  logic               r_tx_line;
  logic               w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == c_CNT_LAST);
  // Pop from idle, or at the end of a stop bit so that queued bytes follow without a gap.
  assign w_pop = !w_empty &&
                 ((r_tx_state == c_TX_IDLE) || ((r_tx_state == c_TX_STOP) && w_tx_bit_end));

  // TX frame FSM with a registered line output. Each state lasts one bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= c_TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        c_TX_IDLE: begin
          r_tx_cnt <= '0;
          if (w_pop) begin
            r_tx_shift <= w_rdata;
            r_tx_line  <= 1'b0;
            r_tx_state <= c_TX_START;
          end
        end
        c_TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= c_TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        c_TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'd7) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= c_TX_STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx_line  <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        c_TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (w_pop) begin
              r_tx_shift <= w_rdata;
              r_tx_line  <= 1'b0;
              r_tx_state <= c_TX_START;
            end else begin
              r_tx_state <= c_TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= c_TX_IDLE;
      endcase
    end
  end

  assign uart.uart_tx_o = r_tx_line;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_echo
//  Purpose  : Self-checking bench for uart_echo at 10 MHz and 115200 baud.
//             A line monitor decodes echoed frames against a scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_echo;

  localparam int      CLK_HZ  = 10_000_000;
  localparam int      BAUD    = 115200;
  localparam realtime BIT_TB  = 8680.6;  // sender bit time
  localparam realtime BIT_DUT = 8700.0;  // echo bit time: 87 clocks of 100 ns

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_echo_if u_if ();

  uart_echo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .uart (u_if)
  );

  always #50 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] exp_q[$];
  bit         rst_seen = 1'b0;
  bit         mon_busy = 1'b0;

  always @(posedge rst) rst_seen = 1'b1;

  // Line monitor: decode each echoed frame at mid-bit and compare it with the scoreboard.
  initial begin : monitor
    logic [9:0] frm;
    logic [7:0] exp_b;
    forever begin
      @(negedge u_if.uart_tx_o);
      rst_seen = 1'b0;
      mon_busy = 1'b1;
      #(BIT_DUT / 2);
      frm[0] = u_if.uart_tx_o;
      for (int i = 1; i < 10; i++) begin
        #(BIT_DUT);
        frm[i] = u_if.uart_tx_o;
      end
      if (!rst_seen && !rst) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL echo_unexpected: got frame %b, required no echo", frm);
        end else begin
          exp_b = exp_q.pop_front();
          if (frm !== {1'b1, exp_b, 1'b0})
            $display("FAIL echo_frame: got frame %b, required %b", frm, {1'b1, exp_b, 1'b0});
          else
            n_pass++;
        end
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #(30_000_000);
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    u_if.uart_rx_i = 1'b0;
    #(BIT_TB);
    for (int i = 0; i < 8; i++) begin
      u_if.uart_rx_i = b[i];
      #(BIT_TB);
    end
    u_if.uart_rx_i = stop_val;
    #(BIT_TB);
    u_if.uart_rx_i = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_bits);
    int polls = 0;
    while ((exp_q.size() != 0 || mon_busy) && polls < max_bits * 87) begin
      #100;
      polls++;
    end
    n_total++;
    if (exp_q.size() != 0 || mon_busy)
      $display("FAIL %s_drain: %0d echoes still pending, required 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.uart_rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (u_if.uart_tx_o !== 1'b1) $display("FAIL reset_tx_in_reset: got %b, required 1", u_if.uart_tx_o);
    else n_pass++;
    #20 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (u_if.uart_tx_o !== 1'b1) $display("FAIL reset_tx_after: got %b, required 1", u_if.uart_tx_o);
    else n_pass++;
  endtask

  task automatic test_idle();
    int lows = 0;
    repeat (20 * 87) begin
      @(negedge clk);
      if (u_if.uart_tx_o !== 1'b1) lows++;
    end
    n_total++;
    if (lows != 0) $display("FAIL idle_line: got %0d low samples, required 0", lows);
    else n_pass++;
  endtask

  task automatic test_single_bytes();
    logic [7:0] vals [3];
    vals = '{8'h3A, 8'hA5, 8'h7E};
    foreach (vals[k]) begin
      exp_q.push_back(vals[k]);
      @(posedge clk);
      #30;
      send_byte(vals[k], 1'b1);
      wait_drain("single", 30);
    end
  endtask

  task automatic test_latency();
    realtime t_end, t_fall, t_rise;
    bit      early;
    int      w;
    exp_q.push_back(8'h55);
    @(posedge clk);
    #30;
    send_byte(8'h55, 1'b1);
    t_end = $realtime;
    early = (u_if.uart_tx_o !== 1'b1);
    w = 0;
    while (u_if.uart_tx_o === 1'b1 && w < 2000) begin
      #1;
      w++;
    end
    t_fall = $realtime;
    n_total++;
    if (early || u_if.uart_tx_o !== 1'b0 || (t_fall - t_end) > 400.0)
      $display("FAIL latency: got %0.1f ns (early=%0b), required 0..400 ns after stop end",
               t_fall - t_end, early);
    else
      n_pass++;
    w = 0;
    while (u_if.uart_tx_o === 1'b0 && w < 20000) begin
      #1;
      w++;
    end
    t_rise = $realtime;
    n_total++;
    if ((t_rise - t_fall) < 8699.0 || (t_rise - t_fall) > 8701.0)
      $display("FAIL start_bit_width: got %0.1f ns, required 8700 ns", t_rise - t_fall);
    else
      n_pass++;
    wait_drain("latency", 30);
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [5];
    vals = '{8'h00, 8'hFF, 8'h81, 8'h18, 8'hC3};
    @(posedge clk);
    #30;
    foreach (vals[k]) begin
      exp_q.push_back(vals[k]);
      send_byte(vals[k], 1'b1);
    end
    wait_drain("back_to_back", 40);
  endtask

  task automatic test_framing_error();
    exp_q.push_back(8'h96);
    @(posedge clk);
    #30;
    send_byte(8'h3C, 1'b0);
    #(BIT_TB * 2);
    send_byte(8'h96, 1'b1);
    wait_drain("framing", 30);
  endtask

  task automatic test_break();
    int lows = 0;
    @(posedge clk);
    #30;
    u_if.uart_rx_i = 1'b0;
    repeat (15 * 87) begin
      @(negedge clk);
      if (u_if.uart_tx_o !== 1'b1) lows++;
    end
    u_if.uart_rx_i = 1'b1;
    repeat (15 * 87) begin
      @(negedge clk);
      if (u_if.uart_tx_o !== 1'b1) lows++;
    end
    n_total++;
    if (lows != 0) $display("FAIL break_no_echo: got %0d low samples, required 0", lows);
    else n_pass++;
  endtask

  task automatic test_reset_tx();
    int w = 0;
    @(posedge clk);
    #30;
    send_byte(8'hA5, 1'b1);  // echo is cut short by reset, so it is not scored
    while (u_if.uart_tx_o === 1'b1 && w < 2000) begin
      #1;
      w++;
    end
    // 2.5 bits into the echo the line carries data bit 1 of 0xA5, which is 0.
    #(BIT_DUT * 2.5 + 13.0);
    n_total++;
    if (u_if.uart_tx_o !== 1'b0)
      $display("FAIL reset_tx_pre: got %b, required 0 before reset", u_if.uart_tx_o);
    else
      n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (u_if.uart_tx_o !== 1'b1)
      $display("FAIL reset_tx_async: got %b, required 1", u_if.uart_tx_o);
    else
      n_pass++;
    #537 rst = 1'b0;
    #(BIT_TB * 2);
    exp_q.push_back(8'h7E);
    @(posedge clk);
    #30;
    send_byte(8'h7E, 1'b1);
    wait_drain("reset_tx", 30);
  endtask

  initial begin
    u_if.uart_rx_i = 1'b1;
    test_reset();
    test_idle();
    test_single_bytes();
    test_latency();
    test_back_to_back();
    test_framing_error();
    test_break();
    test_reset_tx();
    #(BIT_DUT * 2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
